lc3_decode: RTL and testbench
=============================

// Module: lc3_decode
// PURPOSE
//  LC3 Decode stage; directly downstream of Fetch. Captures the instruction word
//  returned from instruction memory together with Fetch's npc_out. Produces the
//  registered IR, npc and the Execute/Writeback/Memory control words that feed Execute.
//  Supports a per-cycle enable (stall) and a branch flush.
// PARAMETERS
//  DATA_W    16  instruction / address width (LC3 fixed; not overridable in practice)
//  IR_RST    16'h0000  IR value loaded on reset and on flush (BR with nzp=000 => NOP)
// PORTS
//  clock          in   1   single global clock, rising edge
//  reset          in   1   asynchronous, active-high
//  enable_decode  in   1   1 = capture new instruction this edge; 0 = hold all outputs
//  flush          in   1   branch taken (br_taken); kills the instruction in decode
//  Instr_dout     in   16  instruction from instruction memory
//  npc_in         in   16  Fetch npc_out (pc+1) belonging to Instr_dout
//  IR             out  16  registered instruction
//  npc_out        out  16  registered npc
//  E_Control      out  6   {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//  W_Control      out  2   0=ALU result, 1=LEA (pcout), 2=memory data
//  Mem_Control    out  1   1 = indirect access (LDI/STI)
//  dec_valid      out  1   IR holds a live instruction
//  illegal_op     out  1   sticky illegal-opcode flag (only with LC3_ILLEGAL_OP_EN)
// BEHAVIOUR
//  - Reset (async): IR=IR_RST, npc_out=0, E_Control=0, W_Control=0, Mem_Control=0,
//    dec_valid=0, illegal_op=0. Release is synchronous to the next clock edge.
//  - Latency 1: on a rising edge with enable_decode=1, IR<=Instr_dout, npc_out<=npc_in,
//    controls <= f(Instr_dout) computed from the incoming word, and dec_valid<=1.
//  - enable_decode=0: every output holds its value (stall), including dec_valid.
//  - flush=1 has priority over enable_decode. It sets IR=IR_RST and controls to 0,
//    keeps npc_out, and sets dec_valid=0.
//  - Control map by opcode IR[15:12] (fields not listed = 0):
//    ADD 0001 / AND 0101: alu=00/01, op2select=~IR[5], W=0
//    NOT 1001: alu=10, op2select=1, W=0
//    BR 0000: pcsel1=01, pcsel2=1        JMP 1100: pcsel1=11, pcsel2=0
//    LD 0010 / LDI 1010: pcsel1=01, pcsel2=1, W=2; Mem=1 for LDI only
//    ST 0011 / STI 1011: pcsel1=01, pcsel2=1; Mem=1 for STI only
//    LDR 0110: pcsel1=10, pcsel2=0, W=2  STR 0111: pcsel1=10, pcsel2=0
//    LEA 1110: pcsel1=01, pcsel2=1, W=1
//    Unsupported (0100, 1000, 1101, 1111): all controls 0
//  - Control output is a pure function of the captured IR. No state beyond the
//    registers listed above.
// CONFIGURATION
//  LC3_ILLEGAL_OP_EN defined: an unsupported opcode captured with enable_decode=1 and
//    flush=0 sets illegal_op=1. It stays set until reset; dec_valid still goes to 1.
//  Undefined: illegal_op is tied to 0, and unsupported opcodes decode silently as all-zero
//    controls.
// STRUCTURE
//  lc3_pkg: opcode enum (op_t), W_Control encodings (WB_ALU/WB_LEA/WB_MEM),
//    E_Control field positions, alu_control codes, IR_RST constant.
//  Sub-module lc3_decode_ctrl: combinational opcode/IR[5] -> {E,W,Mem} lookup.
//  The top holds the registers, the enable/flush priority and the sticky flag.
// TESTING
//  1 reset asserted mid-run with enable_decode=1 -> all outputs 0 immediately, before any
//    clock edge
//  2 Instr_dout=16'h1283 (ADD reg), npc_in=16'h3001, enable=1 -> next edge IR=1283,
//    npc_out=3001, E=6'b000001, W=0, Mem=0, dec_valid=1
//  3 Instr_dout=16'hA405 (LDI) -> E=6'b000110, W=2, Mem=1; then enable=0 with
//    Instr_dout=16'h5020 -> outputs unchanged for 3 cycles
//  4 flush=1 together with enable=1 and Instr_dout=16'h6042 (LDR) -> IR=0000, controls 0,
//    dec_valid=0, npc_out unchanged
//  5 sweep all 16 opcodes with IR[5] in {0,1} -> E/W/Mem match the golden table in lc3_pkg
//  6 LC3_ILLEGAL_OP_EN: load 16'hD000 -> illegal_op=1, then load ADD -> illegal_op stays 1;
//    with the macro undefined, illegal_op stays 0

Source files
------------

// File: rtl/lc3_pkg.sv
// -----------------------------------------------------------------------------
// lc3_pkg
// Shared definitions for the LC3 Decode stage:
//   - op_t       : LC3 opcode encoding of IR[15:12]
//   - wb_t       : W_Control write-back source select
//   - ALU_*      : alu_control codes carried in E_Control
//   - PC1_*      : pcselect1 codes carried in E_Control
//   - E_*        : bit positions of the fields inside E_Control
//   - LC3_W / LC3_IR_RST : datapath width and the NOP word used on reset/flush
//   - is_unsupported()   : true for opcodes this pipeline does not execute
// -----------------------------------------------------------------------------
package lc3_pkg;

    localparam int LC3_W = 16;

    // BR with nzp=000 never branches, so an all-zero IR acts as a NOP.
    localparam logic [LC3_W-1:0] LC3_IR_RST = 16'h0000;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LEA = 2'd1,
        WB_MEM = 2'd2
    } wb_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    // pcselect1 picks the offset field that feeds the address adder.
    localparam logic [1:0] PC1_NONE  = 2'b00;
    localparam logic [1:0] PC1_OFF9  = 2'b01;
    localparam logic [1:0] PC1_OFF6  = 2'b10;
    localparam logic [1:0] PC1_ZERO  = 2'b11;

    // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
    localparam int E_ALU_LSB  = 4;
    localparam int E_PC1_LSB  = 2;
    localparam int E_PC2_BIT  = 1;
    localparam int E_OP2_BIT  = 0;
    localparam int E_W        = 6;

    function automatic logic is_unsupported(input logic [3:0] opcode);
        case (op_t'(opcode))
            OP_JSR, OP_RTI, OP_RES, OP_TRAP: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lc3_decode_if.sv
// -----------------------------------------------------------------------------
// lc3_decode_if
// Bundles the Decode stage's upstream inputs and downstream outputs.
//   master : the Fetch / control side, drives enable_decode, flush, Instr_dout,
//            npc_in and observes the decoded outputs
//   slave  : the Decode stage itself
// Signals:
//   enable_decode, flush, Instr_dout[15:0], npc_in[15:0]            (to decode)
//   IR[15:0], npc_out[15:0], E_Control[5:0], W_Control[1:0],
//   Mem_Control, dec_valid, illegal_op                            (from decode)
// -----------------------------------------------------------------------------
interface lc3_decode_if;

    logic                        enable_decode;
    logic                        flush;
    logic [lc3_pkg::LC3_W-1:0]   Instr_dout;
    logic [lc3_pkg::LC3_W-1:0]   npc_in;

    logic [lc3_pkg::LC3_W-1:0]   IR;
    logic [lc3_pkg::LC3_W-1:0]   npc_out;
    logic [lc3_pkg::E_W-1:0]     E_Control;
    logic [1:0]                  W_Control;
    logic                        Mem_Control;
    logic                        dec_valid;
    logic                        illegal_op;

    modport master (
        output enable_decode, flush, Instr_dout, npc_in,
        input  IR, npc_out, E_Control, W_Control, Mem_Control, dec_valid, illegal_op
    );

    modport slave (
        input  enable_decode, flush, Instr_dout, npc_in,
        output IR, npc_out, E_Control, W_Control, Mem_Control, dec_valid, illegal_op
    );

endinterface

// File: rtl/lc3_decode_ctrl.sv
// -----------------------------------------------------------------------------
// lc3_decode_ctrl
// Combinational control lookup: opcode and the immediate-select bit IR[5]
// map to the Execute, Writeback and Memory control words.
// Ports:
//   opcode    in  4  IR[15:12]
//   imm_sel   in  1  IR[5] (1 = immediate second operand for ADD/AND)
//   e_ctrl    out 6  {alu_control, pcselect1, pcselect2, op2select}
//   w_ctrl    out 2  write-back source (wb_t)
//   mem_ctrl  out 1  indirect memory access (LDI/STI)
// Unsupported opcodes produce all-zero controls.
// -----------------------------------------------------------------------------
module lc3_decode_ctrl
    import lc3_pkg::*;
(
    input  logic [3:0]       opcode,
    input  logic             imm_sel,
    output logic [E_W-1:0]   e_ctrl,
    output logic [1:0]       w_ctrl,
    output logic             mem_ctrl
);

    logic [1:0] alu;
    logic [1:0] pc1;
    logic       pc2;
    logic       op2;
    wb_t        wb;

    always_comb begin
        alu      = ALU_ADD;
        pc1      = PC1_NONE;
        pc2      = 1'b0;
        op2      = 1'b0;
        wb       = WB_ALU;
        mem_ctrl = 1'b0;

        case (op_t'(opcode))
            // op2select=1 selects the register operand, so it is the inverse of IR[5].
            OP_ADD: begin alu = ALU_ADD; op2 = ~imm_sel; end
            OP_AND: begin alu = ALU_AND; op2 = ~imm_sel; end
            OP_NOT: begin alu = ALU_NOT; op2 = 1'b1;     end
            OP_BR:  begin pc1 = PC1_OFF9; pc2 = 1'b1;    end
            OP_JMP: begin pc1 = PC1_ZERO; pc2 = 1'b0;    end
            OP_LD:  begin pc1 = PC1_OFF9; pc2 = 1'b1; wb = WB_MEM; end
            OP_LDI: begin pc1 = PC1_OFF9; pc2 = 1'b1; wb = WB_MEM; mem_ctrl = 1'b1; end
            OP_ST:  begin pc1 = PC1_OFF9; pc2 = 1'b1;    end
            OP_STI: begin pc1 = PC1_OFF9; pc2 = 1'b1; mem_ctrl = 1'b1; end
            OP_LDR: begin pc1 = PC1_OFF6; pc2 = 1'b0; wb = WB_MEM; end
            OP_STR: begin pc1 = PC1_OFF6; pc2 = 1'b0;    end
            OP_LEA: begin pc1 = PC1_OFF9; pc2 = 1'b1; wb = WB_LEA; end
            default: ;
        endcase

        e_ctrl                      = '0;
        e_ctrl[E_ALU_LSB +: 2]      = alu;
        e_ctrl[E_PC1_LSB +: 2]      = pc1;
        e_ctrl[E_PC2_BIT]           = pc2;
        e_ctrl[E_OP2_BIT]           = op2;
        w_ctrl                      = wb;
    end

endmodule

// File: rtl/lc3_decode.sv
// -----------------------------------------------------------------------------
// lc3_decode
// LC3 Decode stage, directly downstream of Fetch. Registers the instruction
// word and its npc, and registers the control words decoded from the incoming
// word so they line up with the captured IR (latency 1).
// Ports:
//   clock   in  rising-edge clock
//   reset   in  asynchronous active-high reset
//   dec     lc3_decode_if.slave:
//             enable_decode (capture / stall), flush (kill, wins over enable),
//             Instr_dout, npc_in -> IR, npc_out, E_Control, W_Control,
//             Mem_Control, dec_valid, illegal_op
// Configuration:
//   LC3_ILLEGAL_OP_EN  when defined, a sticky illegal_op flag is set by any
//                      unsupported opcode captured without flush; otherwise
//                      illegal_op is tied low.
// -----------------------------------------------------------------------------
module lc3_decode
    import lc3_pkg::*;
#(
    parameter int                DATA_W = LC3_W,
    parameter logic [DATA_W-1:0] IR_RST = LC3_IR_RST
)
(
    input  logic        clock,
    input  logic        reset,
    lc3_decode_if.slave dec
);

    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] npc_q;
    logic [E_W-1:0]    e_q;
    logic [1:0]        w_q;
    logic              mem_q;
    logic              valid_q;

    logic [E_W-1:0]    next_e;
    logic [1:0]        next_w;
    logic              next_mem;

    lc3_decode_ctrl u_ctrl (
        .opcode   (dec.Instr_dout[15:12]),
        .imm_sel  (dec.Instr_dout[5]),
        .e_ctrl   (next_e),
        .w_ctrl   (next_w),
        .mem_ctrl (next_mem)
    );

    // Flush turns the stage into a bubble but leaves npc_out alone; a stall
    // simply skips the update so every register holds.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_q    <= IR_RST;
            npc_q   <= '0;
            e_q     <= '0;
            w_q     <= '0;
            mem_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (dec.flush) begin
            ir_q    <= IR_RST;
            e_q     <= '0;
            w_q     <= '0;
            mem_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (dec.enable_decode) begin
            ir_q    <= dec.Instr_dout;
            npc_q   <= dec.npc_in;
            e_q     <= next_e;
            w_q     <= next_w;
            mem_q   <= next_mem;
            valid_q <= 1'b1;
        end
    end

    assign dec.IR          = ir_q;
    assign dec.npc_out     = npc_q;
    assign dec.E_Control   = e_q;
    assign dec.W_Control   = w_q;
    assign dec.Mem_Control = mem_q;
    assign dec.dec_valid   = valid_q;

`ifdef LC3_ILLEGAL_OP_EN
    logic illegal_q;

    // Sticky until reset; a flushed word never counts as executed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (dec.enable_decode && !dec.flush &&
                     is_unsupported(dec.Instr_dout[15:12])) begin
            illegal_q <= 1'b1;
        end
    end

    assign dec.illegal_op = illegal_q;
`else
    assign dec.illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_decode.sv
// -----------------------------------------------------------------------------
// tb_lc3_decode
// Directed self-checking bench for lc3_decode. Inputs are driven 1ns after a
// rising edge and outputs are sampled 1ns after the following rising edge.
// Build with or without LC3_ILLEGAL_OP_EN; the expected illegal_op follows it.
// -----------------------------------------------------------------------------
module tb_lc3_decode;

    logic clock;
    logic reset;

    int tests_run;
    int tests_failed;

`ifdef LC3_ILLEGAL_OP_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    lc3_decode_if dif ();

    lc3_decode dut (
        .clock (clock),
        .reset (reset),
        .dec   (dif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic fl, input logic [15:0] instr,
                         input logic [15:0] npc);
        dif.enable_decode = en;
        dif.flush         = fl;
        dif.Instr_dout    = instr;
        dif.npc_in        = npc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        tick();
        tests_run++;
        if (dif.IR !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_ir: got %h expected 0000", dif.IR);
        end
        tests_run++;
        if (dif.npc_out !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_npc: got %h expected 0000", dif.npc_out);
        end
        tests_run++;
        if ({dif.E_Control, dif.W_Control, dif.Mem_Control} !== 9'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000000",
                     {dif.E_Control, dif.W_Control, dif.Mem_Control});
        end
        tests_run++;
        if ({dif.dec_valid, dif.illegal_op} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected 00",
                     {dif.dec_valid, dif.illegal_op});
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        drive(1'b1, 1'b0, 16'h1283, 16'h3001);
        tick();
        tests_run++;
        if (dif.IR !== 16'h1283) begin
            tests_failed++;
            $display("[TB] FAIL add_ir: got %h expected 1283", dif.IR);
        end
        tests_run++;
        if (dif.npc_out !== 16'h3001) begin
            tests_failed++;
            $display("[TB] FAIL add_npc: got %h expected 3001", dif.npc_out);
        end
        tests_run++;
        if ({dif.E_Control, dif.W_Control, dif.Mem_Control} !== {6'b000001, 2'd0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL add_ctrl: got %b expected 000001000",
                     {dif.E_Control, dif.W_Control, dif.Mem_Control});
        end
        tests_run++;
        if ({dif.dec_valid, dif.illegal_op} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL add_flags: got %b expected 10",
                     {dif.dec_valid, dif.illegal_op});
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 16'hA405, 16'h3002);
        tick();
        tests_run++;
        if ({dif.IR, dif.E_Control, dif.W_Control, dif.Mem_Control} !==
            {16'hA405, 6'b000110, 2'd2, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL ldi_decode: got ir=%h e=%b w=%0d m=%b expected ir=a405 e=000110 w=2 m=1",
                     dif.IR, dif.E_Control, dif.W_Control, dif.Mem_Control);
        end
        drive(1'b0, 1'b0, 16'h5020, 16'h3003);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({dif.IR, dif.npc_out, dif.E_Control, dif.W_Control, dif.Mem_Control,
                 dif.dec_valid} !== {16'hA405, 16'h3002, 6'b000110, 2'd2, 1'b1, 1'b1}) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold cycle %0d: got ir=%h npc=%h e=%b w=%0d m=%b v=%b expected ir=a405 npc=3002 e=000110 w=2 m=1 v=1",
                         i, dif.IR, dif.npc_out, dif.E_Control, dif.W_Control,
                         dif.Mem_Control, dif.dec_valid);
            end
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 16'h6042, 16'h3004);
        tick();
        tests_run++;
        if ({dif.IR, dif.E_Control, dif.W_Control, dif.Mem_Control, dif.dec_valid} !== 26'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_kill: got ir=%h e=%b w=%0d m=%b v=%b expected all zero",
                     dif.IR, dif.E_Control, dif.W_Control, dif.Mem_Control, dif.dec_valid);
        end
        tests_run++;
        if (dif.npc_out !== 16'h3002) begin
            tests_failed++;
            $display("[TB] FAIL flush_npc: got %h expected 3002", dif.npc_out);
        end
        // A flushed unsupported opcode must not raise illegal_op.
        drive(1'b1, 1'b1, 16'hF000, 16'h3005);
        tick();
        tests_run++;
        if ({dif.dec_valid, dif.illegal_op} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL flush_illegal: got %b expected 00",
                     {dif.dec_valid, dif.illegal_op});
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic test_illegal();
        drive(1'b1, 1'b0, 16'hD000, 16'h3010);
        tick();
        tests_run++;
        if ({dif.IR, dif.E_Control, dif.W_Control, dif.Mem_Control, dif.dec_valid,
             dif.illegal_op} !== {16'hD000, 9'b0, 1'b1, ILL_EXP}) begin
            tests_failed++;
            $display("[TB] FAIL illegal_set: got ir=%h e=%b w=%0d m=%b v=%b ill=%b expected ir=d000 ctrl=0 v=1 ill=%b",
                     dif.IR, dif.E_Control, dif.W_Control, dif.Mem_Control,
                     dif.dec_valid, dif.illegal_op, ILL_EXP);
        end
        drive(1'b1, 1'b0, 16'h1283, 16'h3011);
        tick();
        tests_run++;
        if ({dif.E_Control, dif.illegal_op} !== {6'b000001, ILL_EXP}) begin
            tests_failed++;
            $display("[TB] FAIL illegal_sticky: got e=%b ill=%b expected e=000001 ill=%b",
                     dif.E_Control, dif.illegal_op, ILL_EXP);
        end
    endtask

    task automatic test_opcode_sweep();
        logic [15:0] word;
        logic [5:0]  exp_e;
        logic [1:0]  exp_w;
        logic        exp_m;
        for (int op = 0; op < 16; op++) begin
            for (int b5 = 0; b5 < 2; b5++) begin
                word  = {op[3:0], 6'b000000, b5[0], 5'b00000};
                exp_e = 6'b000000;
                exp_w = 2'd0;
                exp_m = 1'b0;
                case (op)
                    0:  exp_e = 6'b000110;
                    1:  exp_e = (b5 == 1) ? 6'b000000 : 6'b000001;
                    2:  begin exp_e = 6'b000110; exp_w = 2'd2; end
                    3:  exp_e = 6'b000110;
                    5:  exp_e = (b5 == 1) ? 6'b010000 : 6'b010001;
                    6:  begin exp_e = 6'b001000; exp_w = 2'd2; end
                    7:  exp_e = 6'b001000;
                    9:  exp_e = 6'b100001;
                    10: begin exp_e = 6'b000110; exp_w = 2'd2; exp_m = 1'b1; end
                    11: begin exp_e = 6'b000110; exp_m = 1'b1; end
                    12: exp_e = 6'b001100;
                    14: begin exp_e = 6'b000110; exp_w = 2'd1; end
                    default: ;
                endcase
                drive(1'b1, 1'b0, word, 16'h4000 + 16'(op * 2 + b5));
                tick();
                tests_run++;
                if ({dif.IR, dif.npc_out, dif.dec_valid} !== {word, 16'h4000 + 16'(op * 2 + b5), 1'b1}) begin
                    tests_failed++;
                    $display("[TB] FAIL sweep_capture op=%h b5=%0d: got ir=%h npc=%h v=%b expected ir=%h npc=%h v=1",
                             op[3:0], b5, dif.IR, dif.npc_out, dif.dec_valid, word,
                             16'h4000 + 16'(op * 2 + b5));
                end
                tests_run++;
                if ({dif.E_Control, dif.W_Control, dif.Mem_Control, dif.illegal_op} !==
                    {exp_e, exp_w, exp_m, ILL_EXP}) begin
                    tests_failed++;
                    $display("[TB] FAIL sweep_ctrl op=%h b5=%0d: got e=%b w=%0d m=%b ill=%b expected e=%b w=%0d m=%b ill=%b",
                             op[3:0], b5, dif.E_Control, dif.W_Control, dif.Mem_Control,
                             dif.illegal_op, exp_e, exp_w, exp_m, ILL_EXP);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 16'hA405, 16'h5555);
        tick();
        // Assert reset between edges; outputs must clear without a clock edge.
        reset = 1'b1;
        #1;
        tests_run++;
        if ({dif.IR, dif.npc_out, dif.E_Control, dif.W_Control, dif.Mem_Control,
             dif.dec_valid, dif.illegal_op} !== 43'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got ir=%h npc=%h e=%b w=%0d m=%b v=%b ill=%b expected all zero",
                     dif.IR, dif.npc_out, dif.E_Control, dif.W_Control, dif.Mem_Control,
                     dif.dec_valid, dif.illegal_op);
        end
        tick();
        reset = 1'b0;
        tick();
        tests_run++;
        if ({dif.IR, dif.npc_out, dif.dec_valid} !== {16'hA405, 16'h5555, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: got ir=%h npc=%h v=%b expected ir=a405 npc=5555 v=1",
                     dif.IR, dif.npc_out, dif.dec_valid);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add();
        test_stall();
        test_flush();
        test_illegal();
        test_opcode_sweep();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
